// File: rtl/params_pkg.sv
// params_pkg: shared bus widths, device IDs and initiator state type
package params_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int NDEV   = 8;
    localparam int DID_W  = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} bus_state_t;

    localparam logic [DID_W-1:0] DRAM   = 3'd0;
    localparam logic [DID_W-1:0] DROM   = 3'd1;
    localparam logic [DID_W-1:0] DUART  = 3'd2;
    localparam logic [DID_W-1:0] DGPIO  = 3'd3;
    localparam logic [DID_W-1:0] DTIMER = 3'd4;
    localparam logic [DID_W-1:0] DSPI   = 3'd5;
    localparam logic [DID_W-1:0] DNON   = 3'd7;

    // A decoded ID is usable only if it names a real device slot
    function automatic logic did_ok(input logic [DID_W-1:0] d);
        return d != DNON && int'(d) < NDEV;
    endfunction
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: WAIT-cycle counter flagging a stalled device
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count (asserted on the cycle before WAIT)
//   tick     : one WAIT cycle elapsed without ready
//   expired  : count reached TIMEOUT_CYC-1
module bus_watchdog #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else if (tick) cnt <= cnt + CW'(1);
    end

    assign expired = cnt == CW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding bus master from core load/store port to device fabric
//   Config macro BUS_TIMEOUT_EN: adds a WAIT watchdog turning stalled devices into errors.
//   req_*    : core request (valid/ready, we, addr, wdata)
//   rsp_*    : core response (valid/ready, rdata, err)
//   bus_*    : registered strobes, address and write data to decoder and devices
//   dec_*    : decoder hit and device ID for the current bus address
//   dev_*    : per-device ready and read data, indexed by device ID
module bus_initiator
    import params_pkg::*;
#(
    parameter int ADDR_W = params_pkg::ADDR_W,
    parameter int DATA_W = params_pkg::DATA_W,
    parameter int NDEV   = params_pkg::NDEV
`ifdef BUS_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   bus_rd,
    output logic                   bus_wr,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [DATA_W-1:0]      bus_wdata,
    input  logic                   dec_hit,
    input  logic [DID_W-1:0]       dec_did,
    input  logic [NDEV-1:0]        dev_ready,
    input  logic [NDEV*DATA_W-1:0] dev_rdata
);
    bus_state_t        state;
    logic [DID_W-1:0]  did_q;
    logic              rdy;
    logic              expired;
    logic [DATA_W-1:0] sel;

    assign rdy = dev_ready[did_q];
    assign sel = dev_rdata[did_q*DATA_W +: DATA_W];

`ifdef BUS_TIMEOUT_EN
    bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ISSUE),
        .tick    (state == WAIT && !rdy),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            did_q     <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    bus_rd    <= !req_we;
                    bus_wr    <= req_we;
                    bus_addr  <= req_addr;
                    bus_wdata <= req_wdata;
                    state     <= ISSUE;
                end
                ISSUE: if (!dec_hit || !did_ok(dec_did)) begin
                    bus_rd    <= 1'b0;
                    bus_wr    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                    state     <= RESP;
                end else begin
                    did_q <= dec_did;
                    state <= WAIT;
                end
                // ready on the expiry cycle still yields a normal response
                WAIT: if (rdy || expired) begin
                    bus_rd    <= 1'b0;
                    bus_wr    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= !rdy;
                    rsp_rdata <= (rdy && bus_rd) ? sel : '0;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: randomized scoreboard bench for bus_initiator with fabric/device model
module tb_bus_initiator;
    import params_pkg::*;

`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid, req_ready, req_we;
    logic [15:0]  req_addr, req_wdata;
    logic         rsp_valid, rsp_err;
    logic         rsp_ready = 1'b0;
    logic [15:0]  rsp_rdata;
    logic         bus_rd, bus_wr;
    logic [15:0]  bus_addr, bus_wdata;
    logic         dec_hit;
    logic [2:0]   dec_did;
    logic [7:0]   dev_ready;
    logic [127:0] dev_rdata;

    always #5 clk = ~clk;

    bus_initiator dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .dec_hit(dec_hit), .dec_did(dec_did),
        .dev_ready(dev_ready), .dev_rdata(dev_rdata)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Fabric address map: top nibble selects a device; 0xE decodes to DNON
    function automatic logic [3:0] decode(input logic [15:0] a);
        case (a[15:12])
            4'h0: return {1'b1, DRAM};
            4'h1: return {1'b1, DROM};
            4'h2: return {1'b1, DUART};
            4'h3: return {1'b1, DGPIO};
            4'h4: return {1'b1, DTIMER};
            4'h6: return {1'b1, DSPI};
            4'h7: return {1'b1, 3'd6};
            4'hE: return {1'b1, DNON};
            default: return 4'b0;
        endcase
    endfunction

    always_comb begin
        dec_hit = 1'b0;
        dec_did = 3'd0;
        if (bus_rd || bus_wr) {dec_hit, dec_did} = decode(bus_addr);
    end

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          lat;
        int          hold;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    exp_t        e_m;
    int          cyc = 0;
    int          acc = 0;
    logic        outstanding = 1'b0;
    int          plan_lat = 0;
    int          plan_sel = 0;
    logic [15:0] devdata[8];
    logic [7:0]  noise = 8'h0;

    // Selected device goes ready once plan_lat WAIT cycles have passed; others are noise
    always_comb begin
        for (int d = 0; d < 8; d++) begin
            dev_rdata[d*16 +: 16] = devdata[d];
            dev_ready[d] = noise[d];
            if (outstanding && d == plan_sel && cyc - acc != 1)
                dev_ready[d] = (cyc - acc >= plan_lat + 2);
        end
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        noise <= 8'($urandom);
        if (rst) outstanding <= 1'b0;
        else begin
            if (req_valid && req_ready) begin
                outstanding <= 1'b1;
                acc <= cyc;
            end
            if (rsp_valid && rsp_ready) outstanding <= 1'b0;
        end
    end

    int          hold = 0;
    logic        in_rsp = 1'b0;
    logic        inflight;
    logic [15:0] s_rdata;
    logic        s_err;

    always @(negedge clk) begin
        if (rst) begin
            in_rsp = 1'b0;
            rsp_ready = 1'b0;
        end else begin
            inflight = outstanding && (cyc - acc <= cur.lat);
            chk("strobe_excl", {31'b0, bus_rd && bus_wr}, 0);
            chk("req_ready", {31'b0, req_ready}, {31'b0, !outstanding});
            chk("bus_rd", {31'b0, bus_rd}, {31'b0, inflight && !cur.we});
            chk("bus_wr", {31'b0, bus_wr}, {31'b0, inflight && cur.we});
            if (inflight) begin
                chk("bus_addr", {16'b0, bus_addr}, {16'b0, cur.addr});
                chk("bus_wdata", {16'b0, bus_wdata}, {16'b0, cur.wdata});
            end
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, outstanding && (cyc - acc > cur.lat)});
            if (rsp_valid) begin
                if (!in_rsp) begin
                    if (q.size() == 0) chk("unexpected_rsp", 1, 0);
                    else begin
                        e_m = q.pop_front();
                        chk("rsp_latency", cyc - acc - 1, e_m.lat);
                        chk("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, e_m.rdata});
                        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e_m.err});
                        hold = e_m.hold;
                    end
                    in_rsp = 1'b1;
                    s_rdata = rsp_rdata;
                    s_err = rsp_err;
                end else begin
                    chk("rsp_rdata_stable", {16'b0, rsp_rdata}, {16'b0, s_rdata});
                    chk("rsp_err_stable", {31'b0, rsp_err}, {31'b0, s_err});
                end
                rsp_ready = (hold == 0);
                if (hold > 0) hold--;
            end else begin
                in_rsp = 1'b0;
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Issue one request; caller and task both sit at a negedge
    task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input int lat, input int hld, input logic keep, input logic [15:0] rdv);
        exp_t e;
        logic [3:0] dd;
        int b;
        b = 0;
        while (!req_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", 0, 1);
            return;
        end
        for (int d = 0; d < 8; d++) devdata[d] = 16'($urandom);
        dd = decode(addr);
        devdata[dd[2:0]] = rdv;
        e.we = we;
        e.addr = addr;
        e.wdata = wdata;
        e.hold = hld;
        if (!dd[3] || dd[2:0] == 3'd7) begin
            e.err = 1'b1;
            e.rdata = 16'h0;
            e.lat = 1;
        end else if (TO_EN && lat >= TO) begin
            e.err = 1'b1;
            e.rdata = 16'h0;
            e.lat = TO + 1;
        end else begin
            e.err = 1'b0;
            e.rdata = we ? 16'h0 : rdv;
            e.lat = lat + 2;
        end
        plan_sel = int'(dd[2:0]);
        plan_lat = lat;
        cur = e;
        q.push_back(e);
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        if (keep) begin
            b = 0;
            while (outstanding && b < 200) begin
                @(negedge clk);
                b++;
            end
            req_valid = 1'b0;
        end else begin
            req_valid = 1'b0;
            req_we = 1'($urandom);
            req_addr = 16'($urandom);
            req_wdata = 16'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 16'h0;
        req_wdata = 16'h0;
        for (int d = 0; d < 8; d++) devdata[d] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 0);
        chk("rst_rsp_rdata", {16'b0, rsp_rdata}, 0);
        chk("rst_bus_rd", {31'b0, bus_rd}, 0);
        chk("rst_bus_wr", {31'b0, bus_wr}, 0);
        chk("rst_bus_addr", {16'b0, bus_addr}, 0);
        chk("rst_bus_wdata", {16'b0, bus_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        txn(1'b0, 16'h0010, 16'h0, 0, 0, 1'b0, 16'hBEEF);
        txn(1'b1, 16'h6002, 16'h1234, 3, 0, 1'b0, 16'h5A5A);
        txn(1'b0, 16'hF000, 16'h0, 0, 0, 1'b0, 16'h7777);
        txn(1'b0, 16'hE123, 16'h0, 0, 1, 1'b0, 16'h1111);
        txn(1'b0, 16'h7ABC, 16'h0, 1, 0, 1'b0, 16'hC0DE);
        txn(1'b0, 16'h0020, 16'h0, 2, 5, 1'b1, 16'hA5A5);

        txn(1'b0, 16'h0100, 16'h0, 10, 0, 1'b0, 16'h4321);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        chk("wrst_req_ready", {31'b0, req_ready}, 1);
        chk("wrst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("wrst_rsp_err", {31'b0, rsp_err}, 0);
        chk("wrst_rsp_rdata", {16'b0, rsp_rdata}, 0);
        chk("wrst_bus_rd", {31'b0, bus_rd}, 0);
        chk("wrst_bus_wr", {31'b0, bus_wr}, 0);
        chk("wrst_bus_addr", {16'b0, bus_addr}, 0);
        chk("wrst_bus_wdata", {16'b0, bus_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn(1'b0, 16'h2200, 16'h0, 1, 0, 1'b0, 16'h9876);

`ifdef BUS_TIMEOUT_EN
        txn(1'b0, 16'h3000, 16'h0, 1000, 0, 1'b0, 16'hDEAD);
        txn(1'b0, 16'h3004, 16'h0, TO - 1, 0, 1'b0, 16'hFACE);
        txn(1'b1, 16'h6010, 16'h4444, TO, 2, 1'b0, 16'h0);
`endif

        for (int i = 0; i < 40; i++)
            txn(1'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(0, TO_EN ? 20 : 6), $urandom_range(0, 3),
                $urandom_range(0, 3) == 0, 16'($urandom));

        b = 0;
        while ((outstanding || q.size() != 0) && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk("drain_queue", q.size(), 0);
        chk("drain_idle", {31'b0, outstanding}, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
